// File: rtl/hazard_unit_if.sv
// Signal bundle between the pipeline datapath and the hazard unit.
// The master is the pipeline side and the slave is the hazard unit.
interface hazard_unit_if;
  logic [4:0]  rsD, rtD, rsE, rtE;
  logic        branchD, jrD;
  logic [4:0]  writeregE, writeregM, writeregW;
  logic        regwriteE, regwriteM, regwriteW;
  logic        memtoregE, memtoregM;
  logic        divE;
  logic        i_busy, d_busy;
  logic [31:0] excepttypeM;
  logic        forwardaD, forwardbD;
  logic [1:0]  forwardaE, forwardbE;
  logic        stallF, stallD, stallE, stallM;
  logic        flushF, flushD, flushE, flushM, flushW;
  logic        exc_fire;
  logic        div_busy;

  modport master (
    output rsD, rtD, rsE, rtE, branchD, jrD,
           writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW,
           memtoregE, memtoregM, divE, i_busy, d_busy, excepttypeM,
    input  forwardaD, forwardbD, forwardaE, forwardbE,
           stallF, stallD, stallE, stallM,
           flushF, flushD, flushE, flushM, flushW,
           exc_fire, div_busy
  );

  modport slave (
    input  rsD, rtD, rsE, rtE, branchD, jrD,
           writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW,
           memtoregE, memtoregM, divE, i_busy, d_busy, excepttypeM,
    output forwardaD, forwardbD, forwardaE, forwardbE,
           stallF, stallD, stallE, stallM,
           flushF, flushD, flushE, flushM, flushW,
           exc_fire, div_busy
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard, forwarding and stall/flush control for the 5-stage MIPS pipeline.
// Holds the divider occupancy counter and defers exceptions until memory traffic drains.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   EXC_IDLE | no exception waiting; an exception without memstall fires now
//   EXC_PEND | exception seen during memstall; fires on first memstall-free cycle
module hazard_unit #(
  parameter int DIV_LAT = 36,
  parameter int CNT_W   = 6
) (
  input logic          clk,
  input logic          rst,
  hazard_unit_if.slave hz
);

  typedef enum logic {EXC_IDLE = 1'b0, EXC_PEND = 1'b1} exc_state_t;

  exc_state_t       r_exc_state, w_exc_state_nxt;
  logic [CNT_W-1:0] r_div_cnt, w_div_cnt_nxt;
  logic             w_memstall, w_lwstall, w_brstall;
  logic             w_div_busy, w_exc_now, w_exc_fire;
  logic             w_e_hits_d, w_m_hits_d;

  assign w_memstall = hz.i_busy | hz.d_busy;
  assign w_exc_now  = (hz.excepttypeM != 32'd0);

  always_comb begin
    hz.forwardaE = 2'b00;
    if (hz.regwriteM && hz.writeregM != 5'd0 && hz.writeregM == hz.rsE)
      hz.forwardaE = 2'b10;
    else if (hz.regwriteW && hz.writeregW != 5'd0 && hz.writeregW == hz.rsE)
      hz.forwardaE = 2'b01;

    hz.forwardbE = 2'b00;
    if (hz.regwriteM && hz.writeregM != 5'd0 && hz.writeregM == hz.rtE)
      hz.forwardbE = 2'b10;
    else if (hz.regwriteW && hz.writeregW != 5'd0 && hz.writeregW == hz.rtE)
      hz.forwardbE = 2'b01;
  end

  assign hz.forwardaD = hz.regwriteM && hz.writeregM != 5'd0 && hz.writeregM == hz.rsD;
  assign hz.forwardbD = hz.regwriteM && hz.writeregM != 5'd0 && hz.writeregM == hz.rtD;

  assign w_e_hits_d = (hz.writeregE != 5'd0) &&
                      (hz.writeregE == hz.rsD || hz.writeregE == hz.rtD);
  assign w_m_hits_d = (hz.writeregM != 5'd0) &&
                      (hz.writeregM == hz.rsD || hz.writeregM == hz.rtD);

  assign w_lwstall = hz.memtoregE && w_e_hits_d;
  assign w_brstall = (hz.branchD || hz.jrD) &&
                     ((hz.regwriteE && w_e_hits_d) || (hz.memtoregM && w_m_hits_d));

  // Busy through the start cycle and while counting; the cycle at count 1 lets E advance.
  assign w_div_busy  = hz.divE && (r_div_cnt != CNT_W'(1));
  assign hz.div_busy = w_div_busy;

  always_comb begin
    w_div_cnt_nxt = r_div_cnt;
    if (w_exc_fire)
      w_div_cnt_nxt = '0;
    else if (r_div_cnt != '0)
      w_div_cnt_nxt = r_div_cnt - CNT_W'(1);
    else if (hz.divE)
      w_div_cnt_nxt = CNT_W'(DIV_LAT - 1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_div_cnt <= '0;
    else      r_div_cnt <= w_div_cnt_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_exc_state <= EXC_IDLE;
    else      r_exc_state <= w_exc_state_nxt;
  end

  always_comb begin
    w_exc_state_nxt = r_exc_state;
    w_exc_fire      = 1'b0;
    case (r_exc_state)
      EXC_IDLE: begin
        if (w_exc_now) begin
          if (w_memstall) w_exc_state_nxt = EXC_PEND;
          else            w_exc_fire      = 1'b1;
        end
      end
      EXC_PEND: begin
        if (!w_memstall) begin
          w_exc_fire      = 1'b1;
          w_exc_state_nxt = EXC_IDLE;
        end
      end
      default: w_exc_state_nxt = EXC_IDLE;
    endcase
  end

  assign hz.exc_fire = w_exc_fire;

  always_comb begin
    hz.stallF = 1'b0;
    hz.stallD = 1'b0;
    hz.stallE = 1'b0;
    hz.stallM = 1'b0;
    hz.flushF = 1'b0;
    hz.flushD = 1'b0;
    hz.flushE = 1'b0;
    hz.flushM = 1'b0;
    hz.flushW = 1'b0;
    if (w_exc_fire) begin
      hz.flushF = 1'b1;
      hz.flushD = 1'b1;
      hz.flushE = 1'b1;
      hz.flushM = 1'b1;
      hz.flushW = 1'b1;
    end else if (w_memstall) begin
      // W registers are never held, so bubble W to avoid repeating its write.
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.stallE = 1'b1;
      hz.stallM = 1'b1;
      hz.flushW = 1'b1;
    end else if (w_div_busy) begin
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.stallE = 1'b1;
      hz.flushM = 1'b1;
    end else if (w_lwstall || w_brstall) begin
      hz.stallF = 1'b1;
      hz.stallD = 1'b1;
      hz.flushE = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding, load/branch stalls, divider
// occupancy, deferred exceptions and asynchronous reset.
module tb_hazard_unit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   busy_cnt;
  int   stalle_cnt;

  hazard_unit_if hz ();

  hazard_unit #(.DIV_LAT(36), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    hz.rsD = 5'd0; hz.rtD = 5'd0; hz.rsE = 5'd0; hz.rtE = 5'd0;
    hz.branchD = 1'b0; hz.jrD = 1'b0;
    hz.writeregE = 5'd0; hz.writeregM = 5'd0; hz.writeregW = 5'd0;
    hz.regwriteE = 1'b0; hz.regwriteM = 1'b0; hz.regwriteW = 1'b0;
    hz.memtoregE = 1'b0; hz.memtoregM = 1'b0;
    hz.divE = 1'b0; hz.i_busy = 1'b0; hz.d_busy = 1'b0;
    hz.excepttypeM = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] stalls();
    return {hz.stallF, hz.stallD, hz.stallE, hz.stallM};
  endfunction

  function automatic logic [4:0] flushes();
    return {hz.flushF, hz.flushD, hz.flushE, hz.flushM, hz.flushW};
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    clr();
    rst = 1'b0;
    #22;
    chk("rst_div_busy", hz.div_busy, 0);
    chk("rst_exc_fire", hz.exc_fire, 0);
    chk("rst_flush", flushes(), 0);
    chk("rst_stall", stalls(), 0);
    chk("rst_cnt", dut.r_div_cnt, 0);
    tick();
    rst = 1'b1;

    // load-use stall, then forwarding from M
    tick();
    hz.rsD = 5'd2; hz.memtoregE = 1'b1; hz.regwriteE = 1'b1; hz.writeregE = 5'd2;
    #1;
    chk("lw_stall", stalls(), 4'b1100);
    chk("lw_flush", flushes(), 5'b00100);
    tick();
    clr();
    hz.memtoregM = 1'b1; hz.regwriteM = 1'b1; hz.writeregM = 5'd2; hz.rsE = 5'd2;
    hz.regwriteW = 1'b1; hz.writeregW = 5'd5; hz.rtE = 5'd5;
    #1;
    chk("lw_fwdaE", hz.forwardaE, 2'b10);
    chk("w_fwdbE", hz.forwardbE, 2'b01);
    chk("lw_nostall", stalls(), 0);
    hz.writeregW = 5'd2; hz.rtE = 5'd2;
    #1;
    chk("m_over_w", hz.forwardbE, 2'b10);
    hz.writeregM = 5'd0; hz.writeregW = 5'd0; hz.rsE = 5'd0; hz.rtE = 5'd0;
    #1;
    chk("r0_fwdE", {hz.forwardaE, hz.forwardbE}, 4'b0000);

    // branch operand hazards
    tick();
    clr();
    hz.regwriteM = 1'b1; hz.writeregM = 5'd3; hz.branchD = 1'b1; hz.rsD = 5'd3;
    #1;
    chk("br_fwdaD", hz.forwardaD, 1);
    chk("br_fwdbD", hz.forwardbD, 0);
    chk("br_m_nostall", stalls(), 0);
    tick();
    clr();
    hz.regwriteE = 1'b1; hz.writeregE = 5'd3; hz.branchD = 1'b1; hz.rsD = 5'd3;
    #1;
    chk("br_e_stall", stalls(), 4'b1100);
    chk("br_e_flush", flushes(), 5'b00100);
    tick();
    clr();
    hz.memtoregM = 1'b1; hz.regwriteM = 1'b1; hz.writeregM = 5'd7; hz.jrD = 1'b1; hz.rtD = 5'd7;
    #1;
    chk("jr_lwm_stall", stalls(), 4'b1100);
    tick();
    clr();
    hz.regwriteE = 1'b1; hz.writeregE = 5'd0; hz.jrD = 1'b1;
    #1;
    chk("jr_r0_nostall", stalls(), 0);

    // divider occupancy
    tick();
    clr();
    hz.divE = 1'b1;
    #1;
    chk("div_start_busy", hz.div_busy, 1);
    chk("div_start_flush", flushes(), 5'b00010);
    busy_cnt = 0;
    stalle_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (!hz.div_busy) break;
      busy_cnt++;
      if (hz.stallE) stalle_cnt++;
      tick();
    end
    chk("div_busy_cycles", busy_cnt, 35);
    chk("div_stallE_cycles", stalle_cnt, 35);
    chk("div_end_stall", stalls(), 0);
    chk("div_end_cnt", dut.r_div_cnt, 1);
    tick();
    hz.divE = 1'b0;
    #1;
    chk("div_idle_cnt", dut.r_div_cnt, 0);
    chk("div_idle_busy", hz.div_busy, 0);

    // exception deferred behind a 4-cycle data stall
    tick();
    clr();
    hz.d_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hz.excepttypeM = (i == 1) ? 32'h4 : 32'h0;
      #1;
      chk($sformatf("mem_stall_%0d", i), stalls(), 4'b1111);
      chk($sformatf("mem_flush_%0d", i), flushes(), 5'b00001);
      chk($sformatf("mem_nofire_%0d", i), hz.exc_fire, 0);
      tick();
    end
    hz.d_busy = 1'b0;
    #1;
    chk("pend_fire", hz.exc_fire, 1);
    chk("pend_flush", flushes(), 5'b11111);
    chk("pend_stall", stalls(), 0);
    tick();
    #1;
    chk("pend_clear", hz.exc_fire, 0);

    // immediate exception
    hz.excepttypeM = 32'h8;
    #1;
    chk("exc_now", hz.exc_fire, 1);
    tick();
    hz.excepttypeM = 32'h0;
    #1;
    chk("exc_once", hz.exc_fire, 0);

    // exception during a divide
    tick();
    clr();
    hz.divE = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    hz.excepttypeM = 32'h1;
    #1;
    chk("divexc_fire", hz.exc_fire, 1);
    chk("divexc_flush", flushes(), 5'b11111);
    chk("divexc_stall", stalls(), 0);
    tick();
    clr();
    #1;
    chk("divexc_cnt", dut.r_div_cnt, 0);
    chk("divexc_busy", hz.div_busy, 0);

    // async reset mid-divide
    tick();
    hz.divE = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    chk("mid_cnt", dut.r_div_cnt, 20);
    #2;
    rst = 1'b0;
    hz.divE = 1'b0;
    #1;
    chk("rstdiv_cnt", dut.r_div_cnt, 0);
    chk("rstdiv_busy", hz.div_busy, 0);
    tick();
    rst = 1'b1;

    // async reset clears a pending exception
    tick();
    hz.d_busy = 1'b1;
    hz.excepttypeM = 32'h2;
    tick();
    hz.excepttypeM = 32'h0;
    #2;
    rst = 1'b0;
    #1;
    hz.d_busy = 1'b0;
    #1;
    chk("rstpend_fire", hz.exc_fire, 0);
    tick();
    rst = 1'b1;
    tick();
    #1;
    chk("rstpend_idle", hz.exc_fire, 0);
    chk("idle_stall", stalls(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
